// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants for the VGA character-buffer arbiter:
//               read-return tag encoding and default RAM geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int CHAR_ADDR_W = 11;
  localparam int CHAR_DATA_W = 8;

  // Tag travelling alongside each RAM access, steering the read return.
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_DISP = 2'd1;
  localparam logic [1:0] TAG_HOST = 2'd2;

endpackage
`default_nettype wire

// File: rtl/vga_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : vga_rd_tag_pipe
// Description : Two-stage tag delay line matching the registered RAM port
//               plus the 1-cycle RAM read, and the demux registers that route
//               the returned data to either the display or the host output.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_rd_tag_pipe
  import vga_pkg::*;
#(
  parameter int DATA_W = CHAR_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        tag_in,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_data_valid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid
);

  // Stage 0 lines up with the registered ram_* drive, stage 1 with ram_rdata.
  logic [1:0] tag_s0;
  logic [1:0] tag_s1;

  // Delay the tag and capture returned data into the owner's output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_s0          <= TAG_NONE;
      tag_s1          <= TAG_NONE;
      disp_data       <= '0;
      disp_data_valid <= 1'b0;
      host_rdata      <= '0;
      host_rvalid     <= 1'b0;
    end else begin
      tag_s0          <= tag_in;
      tag_s1          <= tag_s0;
      disp_data_valid <= (tag_s1 == TAG_DISP);
      host_rvalid     <= (tag_s1 == TAG_HOST);
      if (tag_s1 == TAG_DISP) disp_data  <= ram_rdata;
      if (tag_s1 == TAG_HOST) host_rdata <= ram_rdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_charbuf_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_charbuf_arbiter
// Description : Arbitrates one single-port character RAM between the VGA
//               display fetcher (priority, one-deep pending slot) and a host
//               valid/ready port with a bounded-wait starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_charbuf_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W          = CHAR_ADDR_W,
  parameter int DATA_W          = CHAR_DATA_W,
  parameter int STARVE_MAX      = 15,
  parameter int HOST_BLANK_ONLY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_data_valid,
  input  logic              blank,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              disp_overrun
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  localparam logic       BLANK_GATE = (HOST_BLANK_ONLY != 0);

  logic              disp_pend;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        wait_cnt;

  logic              force_host;
  logic              disp_src;
  logic              grant_host;
  logic              grant_disp;
  logic [ADDR_W-1:0] disp_sel_addr;
  logic [1:0]        tag_grant;
  logic              pend_next;
  logic [ADDR_W-1:0] pend_addr_next;
  logic              drop_req;

  // Grant decision: forced host, else any display source, else eligible host.
  always_comb begin
    force_host    = !BLANK_GATE && host_valid && (wait_cnt == STARVE_LIM);
    disp_src      = disp_pend || disp_req;
    grant_host    = force_host ||
                    (!disp_src && host_valid && (!BLANK_GATE || blank));
    grant_disp    = !force_host && disp_src;
    disp_sel_addr = disp_pend ? pend_addr : disp_addr;
    if (grant_host)      tag_grant = host_we ? TAG_NONE : TAG_HOST;
    else if (grant_disp) tag_grant = TAG_DISP;
    else                 tag_grant = TAG_NONE;
  end

  assign host_ready = grant_host;

  // Pending-slot update: park a blocked live request, drop it if slot is busy.
  always_comb begin
    pend_next      = disp_pend;
    pend_addr_next = pend_addr;
    drop_req       = 1'b0;
    if (force_host) begin
      if (disp_req) begin
        if (disp_pend) begin
          drop_req = 1'b1;
        end else begin
          pend_next      = 1'b1;
          pend_addr_next = disp_addr;
        end
      end
    end else if (disp_pend) begin
      // Slot is served now; a coincident live request takes its place.
      pend_next      = disp_req;
      pend_addr_next = disp_addr;
    end else begin
      pend_next = 1'b0;
    end
  end

  // Arbiter state: pending slot, sticky overrun flag and host wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_pend    <= 1'b0;
      pend_addr    <= '0;
      disp_overrun <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      disp_pend    <= pend_next;
      pend_addr    <= pend_addr_next;
      disp_overrun <= disp_overrun | drop_req;
      if (BLANK_GATE || !host_valid || grant_host) begin
        wait_cnt <= '0;
      end else if (wait_cnt != STARVE_LIM) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // Registered RAM port driven one cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= grant_host || grant_disp;
      ram_we <= grant_host && host_we;
      if (grant_host)      ram_addr <= host_addr;
      else if (grant_disp) ram_addr <= disp_sel_addr;
      if (grant_host && host_we) ram_wdata <= host_wdata;
    end
  end

  vga_rd_tag_pipe #(
    .DATA_W (DATA_W)
  ) u_tag_pipe (
    .clk             (clk),
    .rst_n           (rst_n),
    .tag_in          (tag_grant),
    .ram_rdata       (ram_rdata),
    .disp_data       (disp_data),
    .disp_data_valid (disp_data_valid),
    .host_rdata      (host_rdata),
    .host_rvalid     (host_rvalid)
  );

endmodule
`default_nettype wire
